stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
Multi-cycle control sequencer for the single-datapath Processor. It steps each instruction through fetch, decode, execute, memory and writeback by producing per-stage enables for the instruction cache, Controller, ALU, data cache, register file and PC. It sits between the Controller flags and the datapath clock-enable inputs, and handles cache-ready handshakes, a stall timeout, halt requests and performance counters.

Parameters:
WAIT_TIMEOUT, 15, maximum consecutive cycles spent in FETCH or MEMORY with ready low before faulting (legal range 1..255)
COUNT_WIDTH, 32, width of the cycle and instruction counters

Ports:
clock  input  1  processor clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
run  input  1  start request, sampled only in IDLE
haltRequest  input  1  stop after the current instruction, sampled only in PCUPDATE
instrReady  input  1  instruction cache has valid instruction this cycle
dataReady  input  1  data cache has completed the access this cycle
memReadFlag  input  1  Controller flag, latched at end of DECODE
memWriteFlag  input  1  Controller flag, latched at end of DECODE
regWriteFlag  input  1  Controller flag, latched at end of DECODE
fetchEnable  output  1  high while state==FETCH
decodeEnable  output  1  high while state==DECODE
aluEnable  output  1  high while state==EXECUTE
memEnable  output  1  high while state==MEMORY
regWriteEnable  output  1  high while state==WRITEBACK
pcUpdateEnable  output  1  high while state==PCUPDATE
faultFlag  output  1  high while state==FAULT
stateOUT  output  3  current state encoding
cycleCount  output  COUNT_WIDTH  active cycles executed
instrCount  output  COUNT_WIDTH  instructions retired

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPDATE=6, FAULT=7.
- All enable outputs and faultFlag are Moore outputs decoded from the state register only. Exactly one enable is high in states 1..6. All are low in IDLE.
- Reset has priority over everything. On the next edge: state=IDLE, all outputs 0, counters 0, latched flags 0, wait counter 0. A reset asserted mid-instruction abandons that instruction with no PC update.
- IDLE: if run=1, go to FETCH; otherwise stay in IDLE.
- FETCH: if instrReady=1, go to DECODE. Otherwise increment the wait counter.
- DECODE: unconditionally go to EXECUTE. At this edge, latch memReadFlag, memWriteFlag and regWriteFlag internally. Flag changes after this point are ignored for the rest of the instruction.
- EXECUTE transitions, using latched flags:
  - if memRead or memWrite, go to MEMORY;
  - else if regWrite, go to WRITEBACK;
  - else go to PCUPDATE (branch/no-op path).
- MEMORY: if dataReady=1, go to WRITEBACK when latched memRead and regWrite are both set, otherwise go to PCUPDATE. If dataReady=0, increment the wait counter.
- Read and write both latched: treat as a read for the transition.
- WRITEBACK: unconditionally go to PCUPDATE.
- PCUPDATE: increment instrCount. Go to IDLE if haltRequest=1, otherwise go to FETCH.
- Wait counter:
  - cleared on every state change;
  - when waitCount==WAIT_TIMEOUT-1 and ready is still low, the next state is FAULT;
  - FETCH or MEMORY therefore lasts at most WAIT_TIMEOUT cycles;
  - if ready=1 on the timeout cycle, ready wins and no fault occurs.
- FAULT: sticky; only reset exits. Counters freeze.
- cycleCount increments on every edge where the current state is 1..6.
- Both counters wrap modulo 2^COUNT_WIDTH with no saturation.
- Latency with ready high on first cycle:
  - ALU register op: 5 cycles (F,D,E,W,P);
  - load: 6 cycles;
  - store: 5 cycles;
  - branch/no-op: 4 cycles.
- run and haltRequest are ignored outside IDLE and PCUPDATE respectively.

Test Plan:
1. Reset, run=1 for 1 cycle, instrReady=1, regWriteFlag=1 only, haltRequest=1 -> states 1,2,3,5,6,0. pcUpdateEnable high 1 cycle. instrCount=1, cycleCount=5.
2. Load: memRead=regWrite=1, dataReady low for 3 MEMORY cycles then high, haltRequest=1 -> MEMORY lasts 4 cycles, then WRITEBACK, PCUPDATE. cycleCount=9.
3. Store: memWriteFlag=1, dataReady=1; toggle regWriteFlag after DECODE -> path 1,2,3,4,6 with no WRITEBACK (latched flags used).
4. WAIT_TIMEOUT=4, instrReady held 0 -> FETCH for 4 cycles, then state 7, faultFlag=1. Stays there for 20 cycles, counters frozen. reset returns to IDLE with counters 0.
5. WAIT_TIMEOUT=4, instrReady rises on the 4th FETCH cycle -> DECODE, no fault.
6. Branch loop with haltRequest=0 for 3 instructions -> 4-cycle loop 1,2,3,6 repeated. instrCount=3, cycleCount=12. Reset asserted in EXECUTE -> IDLE next edge, no pcUpdateEnable pulse.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Handshake and control bundle between the stage sequencer and the datapath.
// The sequencer side uses the master modport; the datapath/driver side uses slave.
interface stage_sequencer_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   run;
  logic                   haltRequest;
  logic                   instrReady;
  logic                   dataReady;
  logic                   memReadFlag;
  logic                   memWriteFlag;
  logic                   regWriteFlag;
  logic                   fetchEnable;
  logic                   decodeEnable;
  logic                   aluEnable;
  logic                   memEnable;
  logic                   regWriteEnable;
  logic                   pcUpdateEnable;
  logic                   faultFlag;
  logic [2:0]             stateOUT;
  logic [COUNT_WIDTH-1:0] cycleCount;
  logic [COUNT_WIDTH-1:0] instrCount;

  modport master (
    input  run, haltRequest, instrReady, dataReady,
           memReadFlag, memWriteFlag, regWriteFlag,
    output fetchEnable, decodeEnable, aluEnable, memEnable,
           regWriteEnable, pcUpdateEnable, faultFlag,
           stateOUT, cycleCount, instrCount
  );

  modport slave (
    output run, haltRequest, instrReady, dataReady,
           memReadFlag, memWriteFlag, regWriteFlag,
    input  fetchEnable, decodeEnable, aluEnable, memEnable,
           regWriteEnable, pcUpdateEnable, faultFlag,
           stateOUT, cycleCount, instrCount
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: steps each instruction through fetch..pcupdate,
// producing registered one-hot stage enables, a stall-timeout fault and counters.
module stage_sequencer #(
  parameter int WAIT_TIMEOUT = 15,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  stage_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    PCUPDATE  = 3'd6,
    FAULT     = 3'd7
  } stateT;

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_TIMEOUT - 1);

  stateT                  state;
  stateT                  nextState;
  logic [7:0]             waitCount;
  logic                   memReadLatched;
  logic                   memWriteLatched;
  logic                   regWriteLatched;
  logic [COUNT_WIDTH-1:0] cycleCounter;
  logic [COUNT_WIDTH-1:0] instrCounter;
  logic                   fetchReg;
  logic                   decodeReg;
  logic                   aluReg;
  logic                   memReg;
  logic                   regWriteReg;
  logic                   pcUpdateReg;
  logic                   faultReg;
  logic                   timedOut;

  assign timedOut = (waitCount == LAST_WAIT);

  always_comb begin
    // NOTE: default first so every path assigns nextState; without it a latch is inferred.
    nextState = state;
    unique case (state)
      IDLE:      if (bus.run) nextState = FETCH;
      FETCH: begin
        if (bus.instrReady)  nextState = DECODE;
        else if (timedOut)   nextState = FAULT;
      end
      DECODE:    nextState = EXECUTE;
      EXECUTE: begin
        if (memReadLatched || memWriteLatched) nextState = MEMORY;
        else if (regWriteLatched)              nextState = WRITEBACK;
        else                                   nextState = PCUPDATE;
      end
      MEMORY: begin
        // A read+write pair follows the read path, so only memRead gates writeback.
        if (bus.dataReady)
          nextState = (memReadLatched && regWriteLatched) ? WRITEBACK : PCUPDATE;
        else if (timedOut)
          nextState = FAULT;
      end
      WRITEBACK: nextState = PCUPDATE;
      PCUPDATE:  nextState = bus.haltRequest ? IDLE : FETCH;
      FAULT:     nextState = FAULT;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register here sees pre-edge values.
    if (reset) begin
      state           <= IDLE;
      waitCount       <= '0;
      memReadLatched  <= 1'b0;
      memWriteLatched <= 1'b0;
      regWriteLatched <= 1'b0;
      cycleCounter    <= '0;
      instrCounter    <= '0;
      fetchReg        <= 1'b0;
      decodeReg       <= 1'b0;
      aluReg          <= 1'b0;
      memReg          <= 1'b0;
      regWriteReg     <= 1'b0;
      pcUpdateReg     <= 1'b0;
      faultReg        <= 1'b0;
    end else begin
      state <= nextState;

      if (nextState != state)
        waitCount <= '0;
      else if (state == FETCH || state == MEMORY)
        waitCount <= waitCount + 8'd1;

      if (state == DECODE) begin
        memReadLatched  <= bus.memReadFlag;
        memWriteLatched <= bus.memWriteFlag;
        regWriteLatched <= bus.regWriteFlag;
      end

      if (state != IDLE && state != FAULT)
        cycleCounter <= cycleCounter + 1'b1;
      if (state == PCUPDATE)
        instrCounter <= instrCounter + 1'b1;

      // Enables are decoded from the upcoming state so they align with stateOUT.
      fetchReg    <= (nextState == FETCH);
      decodeReg   <= (nextState == DECODE);
      aluReg      <= (nextState == EXECUTE);
      memReg      <= (nextState == MEMORY);
      regWriteReg <= (nextState == WRITEBACK);
      pcUpdateReg <= (nextState == PCUPDATE);
      faultReg    <= (nextState == FAULT);
    end
  end

  assign bus.fetchEnable    = fetchReg;
  assign bus.decodeEnable   = decodeReg;
  assign bus.aluEnable      = aluReg;
  assign bus.memEnable      = memReg;
  assign bus.regWriteEnable = regWriteReg;
  assign bus.pcUpdateEnable = pcUpdateReg;
  assign bus.faultFlag      = faultReg;
  assign bus.stateOUT       = state;
  assign bus.cycleCount     = cycleCounter;
  assign bus.instrCount     = instrCounter;

endmodule
